// File: rtl/dar_router.sv
// dar_router: NCH-channel audio router with a serially programmed, parity-checked select/mute map.
// The routed output port is named dout because do is a reserved word.
module dar_router #(
  parameter int NCH = 4,
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] di,
  output logic [NCH*W-1:0] dout,
  input  logic             prgrm_in,
  input  logic             prgrm_go_,
  output logic             prgrm_busy,
  output logic             err_
);
  localparam int SEL_W = $clog2(NCH);
  localparam int F = SEL_W + 1;
  localparam int P = NCH * F;
  localparam int CW = $clog2(P + 1);
  localparam logic [SEL_W:0] NCH_V = F'(NCH);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [P-1:0] shd, shd_n;
  logic err_n, load, sel_ok;
  logic [SEL_W-1:0] sel [NCH];
  logic [SEL_W-1:0] nsel [NCH];
  logic [NCH-1:0] mute, nmute;

  assign prgrm_busy = state != IDLE;

  // Channel 0 arrives first, so it ends up in the top field of the shadow.
  always_comb begin
    sel_ok = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      nsel[k] = shd[P-1-k*F -: SEL_W];
      nmute[k] = shd[P-1-k*F-SEL_W];
      sel_ok = sel_ok & ({1'b0, nsel[k]} < NCH_V);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shd_n = shd;
    err_n = err_;
    load = 1'b0;
    unique case (state)
      IDLE: begin
        if (!prgrm_go_) begin
          state_n = prgrm_in ? SHIFT : IDLE;
          cnt_n = '0;
          err_n = prgrm_in ? err_ : 1'b0;
        end
      end
      SHIFT: begin
        if (!prgrm_go_) begin
          state_n = IDLE;
          shd_n = '0;
          err_n = 1'b0;
        end else begin
          shd_n = {shd[P-2:0], prgrm_in};
          cnt_n = cnt + CW'(1);
          state_n = (cnt == CW'(P - 1)) ? PAR : SHIFT;
        end
      end
      PAR: begin
        state_n = IDLE;
        if (!prgrm_go_) begin
          shd_n = '0;
          err_n = 1'b0;
        end else begin
          load = ((^shd) == prgrm_in) && sel_ok;
          err_n = load;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shd <= '0;
      err_ <= 1'b1;
      mute <= '0;
      for (int k = 0; k < NCH; k++) sel[k] <= SEL_W'(k);
      dout <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shd <= shd_n;
      err_ <= err_n;
      if (load) begin
        sel <= nsel;
        mute <= nmute;
      end
      for (int k = 0; k < NCH; k++) dout[k*W +: W] <= mute[k] ? '0 : di[int'(sel[k])*W +: W];
    end
  end
endmodule

// File: tb/tb_dar_router.sv
// tb_dar_router: directed frames against a frame-level map model, plus an NCH=3 instance for the sel range check.
module tb_dar_router;
  localparam int P = 12;
  localparam logic [63:0] ID  = {16'h7fff, 16'h0123, 16'hff00, 16'h00f8};
  localparam logic [63:0] REV = {16'h00f8, 16'hff00, 16'h0123, 16'h7fff};
  localparam logic [63:0] MUT = {16'h7fff, 16'h0000, 16'hff00, 16'h00f8};
  localparam logic [P-1:0] REV_P = 12'b110_100_010_000;
  localparam logic [P-1:0] MUT_P = 12'b000_010_101_110;
  localparam logic [P-1:0] ID_P  = 12'b000_010_100_110;

  logic clk = 1'b0, rst = 1'b1;
  logic [63:0] di = ID, dout;
  logic prgrm_in = 1'b0, prgrm_go_ = 1'b1, prgrm_busy, err_;
  logic [47:0] di3 = {16'h0123, 16'hff00, 16'h00f8}, dout3;
  logic in3 = 1'b0, go3 = 1'b1, busy3, err3;

  always #5 clk = ~clk;

  dar_router #(.NCH(4), .W(16)) dut (.clk(clk), .rst(rst), .di(di), .dout(dout), .prgrm_in(prgrm_in),
    .prgrm_go_(prgrm_go_), .prgrm_busy(prgrm_busy), .err_(err_));
  dar_router #(.NCH(3), .W(16)) dut3 (.clk(clk), .rst(rst), .di(di3), .dout(dout3), .prgrm_in(in3),
    .prgrm_go_(go3), .prgrm_busy(busy3), .err_(err3));

  int n_chk = 0, n_fail = 0, busy_cnt = 0;
  bit chk_en = 0;
  logic n_rst = 1'b1, n_busy = 1'b0, n_err = 1'b1, n_ld = 1'b0;
  logic [P-1:0] n_pl = '0;
  int m_sel [4];
  bit m_mute [4];
  logic m_err = 1'b1, m_busy = 1'b0;
  logic [63:0] exp_do = '0;

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // The payload is a bit stream in send order: per channel, select bits MSB first, then mute.
  task automatic apply_map(input logic [P-1:0] pl);
    int s [4];
    for (int c = 0; c < 4; c++) s[c] = 0;
    for (int b = 0; b < P; b++) begin
      if (b % 3 < 2) s[b/3] = s[b/3] * 2 + int'(pl[P-1-b]);
      else m_mute[b/3] = pl[P-1-b];
    end
    for (int c = 0; c < 4; c++) m_sel[c] = s[c];
  endtask

  always @(posedge clk) begin
    if (n_rst) begin
      exp_do = '0;
      for (int c = 0; c < 4; c++) begin
        m_sel[c] = c;
        m_mute[c] = 0;
      end
      m_err = 1'b1;
      m_busy = 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) exp_do[c*16 +: 16] = m_mute[c] ? 16'h0 : di[m_sel[c]*16 +: 16];
      m_err = n_err;
      m_busy = n_busy;
      if (n_ld) apply_map(n_pl);
    end
    chk_en = 1;
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("do", dout, exp_do);
      check("err_", 64'(err_), 64'(m_err));
      check("busy", 64'(prgrm_busy), 64'(m_busy));
      if (prgrm_busy) busy_cnt++;
    end
  end

  // e < 0 keeps the current expected err_, otherwise e[0] is the err_ expected after this edge.
  task automatic step(input logic r, input logic g, input logic i, input logic b, input int e,
                      input logic ld, input logic [P-1:0] pl);
    @(negedge clk);
    rst = r;
    prgrm_go_ = g;
    prgrm_in = i;
    n_rst = r;
    n_busy = b;
    n_err = (e < 0) ? m_err : e[0];
    n_ld = ld;
    n_pl = pl;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0, '0);
  endtask

  task automatic frame(input logic [P-1:0] pl, input logic par, input int abort_at = -1, input int rst_at = -1);
    bit ok;
    ok = (($countones(pl) + int'(par)) % 2) == 0;
    step(1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, '0);
    for (int t = 1; t <= P; t++) begin
      if (t == abort_at) begin
        step(1'b0, 1'b0, pl[P-t], 1'b0, 0, 1'b0, '0);
        return;
      end
      if (t == rst_at) begin
        step(1'b1, 1'b1, pl[P-t], 1'b0, 1, 1'b0, '0);
        return;
      end
      step(1'b0, 1'b1, pl[P-t], 1'b1, -1, 1'b0, '0);
    end
    step(1'b0, 1'b1, par, 1'b0, ok ? 1 : 0, ok, pl);
  endtask

  task automatic step3(input logic g, input logic i);
    @(negedge clk);
    go3 = g;
    in3 = i;
  endtask

  task automatic frame3(input logic [8:0] pl, input logic par);
    step3(1'b0, 1'b1);
    for (int t = 1; t <= 9; t++) step3(1'b1, pl[9-t]);
    check("busy3_parity", 64'(busy3), 64'd1);
    step3(1'b1, par);
    step3(1'b1, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, '0);
    idle();
    check("reset_do", dout, 64'h0);
    check("reset_err", 64'(err_), 64'd1);
    check("reset_busy", 64'(prgrm_busy), 64'd0);
    idle();
    check("identity", dout, ID);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0, '0);
    check("in_ignored_idle", 64'(prgrm_busy), 64'd0);
    busy_cnt = 0;
    frame(REV_P, 1'b0);
    idle();
    check("busy_cycles", 64'(busy_cnt), 64'd13);
    check("rev_err", 64'(err_), 64'd1);
    idle();
    check("rev_do", dout, REV);
    frame(REV_P, 1'b0);
    frame(MUT_P, 1'b1);
    idle();
    idle();
    check("mute_do", dout, MUT);
    check("mute_err", 64'(err_), 64'd1);
    di = 64'h1111_2222_3333_4444;
    idle();
    idle();
    check("mute_do_pattern", dout, 64'h1111_0000_3333_4444);
    for (int n = 0; n < 3; n++) begin
      di = {$urandom, $urandom};
      idle();
    end
    di = ID;
    idle();
    frame(ID_P, 1'b1);
    idle();
    check("bad_parity_err", 64'(err_), 64'd0);
    idle();
    check("bad_parity_map", dout, MUT);
    frame(ID_P, 1'b0);
    idle();
    check("restore_err", 64'(err_), 64'd1);
    idle();
    check("id_do", dout, ID);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0);
    idle();
    check("start0_err", 64'(err_), 64'd0);
    check("start0_busy", 64'(prgrm_busy), 64'd0);
    frame(REV_P, 1'b0);
    idle();
    check("restore2_err", 64'(err_), 64'd1);
    frame(MUT_P, 1'b1, 5);
    idle();
    check("abort_err", 64'(err_), 64'd0);
    check("abort_busy", 64'(prgrm_busy), 64'd0);
    idle();
    check("abort_map", dout, REV);
    frame(MUT_P, 1'b1);
    idle();
    idle();
    check("restore3_err", 64'(err_), 64'd1);
    check("restore3_do", dout, MUT);
    frame(REV_P, 1'b0, -1, 6);
    idle();
    check("midrst_do", dout, 64'h0);
    check("midrst_err", 64'(err_), 64'd1);
    check("midrst_busy", 64'(prgrm_busy), 64'd0);
    frame(REV_P, 1'b0);
    idle();
    idle();
    check("post_rst_frame", dout, REV);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, '0);
    idle();
    check("rst_vs_start_busy", 64'(prgrm_busy), 64'd0);
    idle();
    check("rst_vs_start_do", dout, ID);
    idle();
    check("nch3_identity", 64'(dout3), 64'({16'h0123, 16'hff00, 16'h00f8}));
    frame3(9'b000_110_100, 1'b1);
    check("nch3_badsel_err", 64'(err3), 64'd0);
    check("nch3_badsel_busy", 64'(busy3), 64'd0);
    step3(1'b1, 1'b0);
    check("nch3_badsel_map", 64'(dout3), 64'({16'h0123, 16'hff00, 16'h00f8}));
    frame3(9'b100_000_010, 1'b0);
    check("nch3_good_err", 64'(err3), 64'd1);
    step3(1'b1, 1'b0);
    check("nch3_good_map", 64'(dout3), 64'({16'hff00, 16'h00f8, 16'h0123}));
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dar_router.md
# dar_router

Parametrised digital audio router, the successor to the fixed 4-channel audio_app. It routes NCH input channels of W-bit samples to NCH registered outputs through a per-output select/mute map. The map is loaded by a serial programming frame on prgrm_in/prgrm_go_, checked by a start bit and even parity, and applied atomically. It sits between the audio input capture and the downstream processing chain, and it reports malformed frames on a sticky active-low err_.

## Interface
- NCH, 4, number of input and output channels (2..16)
- W, 16, sample width in bits
- SEL_W, $clog2(NCH), derived localparam; width of one select field
- P, NCH*(SEL_W+1), derived localparam; payload bit count per frame
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- di  input  NCH*W  input samples; channel k is di[k*W +: W]
- do  output  NCH*W  routed samples; channel k is do[k*W +: W]
- prgrm_in  input  1  serial programming data, sampled every clk
- prgrm_go_  input  1  active-low frame start strobe
- prgrm_busy  output  1  high while a frame is being shifted in
- err_  output  1  active-low sticky frame error

## Operation
- Map state: sel[k] (SEL_W bits) and mute[k] for each output k.
- Datapath: each clk, do[k] <= mute[k] ? 0 : di[sel[k]].
- FSM states:
  - IDLE: sample prgrm_go_ each cycle. go_=0 with prgrm_in=1 (start bit) -> SHIFT, bit count cleared. go_=0 with prgrm_in=0 -> err_<=0, remain IDLE.
  - SHIFT: shift prgrm_in into the shadow register for P cycles. Field order is channel 0 first; per channel, sel MSB first, then the mute bit. The next cycle is the parity bit -> CHECK logic.
  - CHECK (evaluated on the parity-bit cycle, then back to IDLE):
    - Accept when XOR(payload) == parity bit and every sel < NCH. Shadow -> live map, err_<=1.
    - Otherwise live map is unchanged and err_<=0.
- prgrm_go_=0 during any SHIFT or parity cycle:
  - abort, discard shadow, err_<=0, return to IDLE;
  - that cycle is not a new start.
- err_ stays low until the next accepted frame or rst.
- prgrm_busy=1 in SHIFT and on the parity cycle; 0 otherwise.

## Timing
- Reset (rst=1 at an edge):
  - do=0, err_=1, prgrm_busy=0, FSM=IDLE;
  - sel[k]=k (identity), mute[k]=0, shadow cleared.
- Reset asserted mid-frame discards the frame, with the same reset values.
- Data latency is one cycle: di sampled at edge n appears on do after edge n.
- Frame length is P+2 cycles: start (T0), payload T1..TP, parity TP+1.
  - The live map updates at the TP+1 edge.
  - do computed at edge TP+2 uses the new map.
  - The update is atomic across all channels, with no mixed-map cycle.
  - err_ updates at the TP+1 edge.
- Back-to-back frames are allowed: a start on the cycle after TP+1 is legal.
- Simultaneous rst and start: rst wins.
- NCH not a power of two: a sel >= NCH rejects the frame even when parity is good.
- prgrm_in is ignored in IDLE unless go_=0.

## Test plan
Default parameters: NCH=4, W=16, P=12, frame 14 cycles. di0..3 = 00f8, ff00, 0123, 7fff.

- Reset -> do=0 for one cycle, then do0..3 = 00f8, ff00, 0123, 7fff (identity). err_=1, prgrm_busy=0.
- Reverse-map frame: start=1, payload 110 100 010 000, parity=0.
  - Required: err_=1, prgrm_busy high for 13 cycles.
  - From TP+2: do0..3 = 7fff, 0123, ff00, 00f8.
- Mute channel 2: payload 000 010 101 110, parity=1.
  - Required: do2=0000, other outputs per map, err_=1.
- Bad frames (live map unchanged in every case):
  - parity bit flipped -> err_=0 at TP+1;
  - start bit 0 -> err_=0 next cycle;
  - go_ pulsed low at T5 -> err_=0 and prgrm_busy=0 next cycle.
  - A following valid frame restores err_=1.
- rst pulsed at T6 of a valid frame -> identity map, err_=1. A fresh frame started two cycles later is accepted.
- NCH=3 build (SEL_W=2, P=9): frame with sel=3 on channel 1 and correct parity -> err_=0, map unchanged.
